// File: rtl/mipi_payload_tracker_if.sv
// mipi_payload_tracker_if: bus between lane merger, tracker and packet handler.
//   Parameters: LANES bytes per beat, WC_W word-count width.
//   Inputs to the tracker: pkt_start, wc, beat_valid, din.
//   Outputs of the tracker: pay_valid, pay_data, pay_keep, pay_last,
//   ftr, ftr_valid, busy, hdr_err, crc_err.
//   master = driver side (merger/testbench), slave = tracker side.
interface mipi_payload_tracker_if #(
   parameter int LANES = 4,
   parameter int WC_W  = 16
);
   logic                  pkt_start;
   logic [WC_W-1:0]       wc;
   logic                  beat_valid;
   logic [8*LANES-1:0]    din;
   logic                  pay_valid;
   logic [8*LANES-1:0]    pay_data;
   logic [LANES-1:0]      pay_keep;
   logic                  pay_last;
   logic [15:0]           ftr;
   logic                  ftr_valid;
   logic                  busy;
   logic                  hdr_err;
   logic                  crc_err;

   modport master (
      output pkt_start, wc, beat_valid, din,
      input  pay_valid, pay_data, pay_keep, pay_last, ftr, ftr_valid, busy, hdr_err, crc_err
   );

   modport slave (
      input  pkt_start, wc, beat_valid, din,
      output pay_valid, pay_data, pay_keep, pay_last, ftr, ftr_valid, busy, hdr_err, crc_err
   );
endinterface

// File: rtl/mipi_payload_tracker.sv
// mipi_payload_tracker: counts long-packet payload bytes against WC for any
// lane count, emits keep-masked payload beats and captures the 2-byte footer.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : mipi_payload_tracker_if.slave (header/beat inputs, payload,
//                footer and error outputs, all outputs registered)
//   Optional macro MIPI_PAYLOAD_CRC_CHK_EN adds a CRC-16 check of the payload
//   against the footer; without it crc_err is tied to 0.
module mipi_payload_tracker #(
   parameter int LANES = 4,
   parameter int WC_W  = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   mipi_payload_tracker_if.slave bus
);
   typedef enum logic [1:0] {IDLE, PAYLOAD, FOOTER} state_t;

   localparam int CW = WC_W + 1;
   localparam logic [CW-1:0] LN = CW'(LANES);

   state_t             state, state_nxt;
   logic [CW-1:0]      rem_pay, rem_ftr, rem_pay_nxt, rem_ftr_nxt;
   logic [CW-1:0]      n_pay, n_ftr;
   logic               fire, ftr_done;
   logic [LANES-1:0]   keep;
   logic [15:0]        fb;
   logic [15:0]        ftr_q, ftr_nxt;
   logic               pay_valid_q, pay_last_q, ftr_valid_q, busy_q, hdr_err_q;
   logic [8*LANES-1:0] pay_data_q;
   logic [LANES-1:0]   pay_keep_q;

   always_comb begin
      fire        = bus.beat_valid && (state != IDLE);
      n_pay       = (state == PAYLOAD) ? ((rem_pay < LN) ? rem_pay : LN) : '0;
      n_ftr       = ((LN - n_pay) < rem_ftr) ? (LN - n_pay) : rem_ftr;
      // bytes right after the last payload byte, in wire order
      fb          = 16'({8'h00, bus.din} >> {n_pay, 3'b000});
      keep        = '0;
      for (int i = 0; i < LANES; i++) keep[i] = CW'(i) < n_pay;
      rem_pay_nxt = rem_pay;
      rem_ftr_nxt = rem_ftr;
      state_nxt   = state;
      ftr_nxt     = ftr_q;
      if (fire) begin
         rem_pay_nxt = rem_pay - n_pay;
         rem_ftr_nxt = rem_ftr - n_ftr;
         state_nxt   = (rem_ftr_nxt == '0) ? IDLE : (rem_pay_nxt == '0) ? FOOTER : PAYLOAD;
         if (n_ftr != '0) begin
            // the first footer byte of this beat lands in slot 2-rem_ftr
            if (rem_ftr == CW'(2)) ftr_nxt[7:0] = fb[7:0];
            else ftr_nxt[15:8] = fb[7:0];
            if (n_ftr == CW'(2)) ftr_nxt[15:8] = fb[15:8];
         end
      end else if (state == IDLE && bus.pkt_start) begin
         rem_pay_nxt = {1'b0, bus.wc};
         rem_ftr_nxt = CW'(2);
         state_nxt   = (bus.wc != '0) ? PAYLOAD : FOOTER;
      end
      ftr_done = fire && (n_ftr != '0) && (rem_ftr_nxt == '0);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         rem_pay     <= '0;
         rem_ftr     <= '0;
         ftr_q       <= '0;
         pay_valid_q <= 1'b0;
         pay_last_q  <= 1'b0;
         ftr_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         hdr_err_q   <= 1'b0;
         pay_data_q  <= '0;
         pay_keep_q  <= '0;
      end else begin
         state       <= state_nxt;
         rem_pay     <= rem_pay_nxt;
         rem_ftr     <= rem_ftr_nxt;
         ftr_q       <= ftr_nxt;
         pay_valid_q <= fire && (n_pay != '0);
         pay_last_q  <= fire && (n_pay != '0) && (rem_pay_nxt == '0);
         ftr_valid_q <= ftr_done;
         busy_q      <= state != IDLE;
         hdr_err_q   <= bus.pkt_start && (state != IDLE);
         // payload registers hold their last beat across gaps and footer beats
         if (fire && n_pay != '0) begin
            pay_data_q <= bus.din;
            pay_keep_q <= keep;
         end
      end
   end

`ifdef MIPI_PAYLOAD_CRC_CHK_EN
   logic [15:0] crc, crc_nxt;
   logic        crc_err_q;

   // reflected CCITT polynomial (0x8408) gives LSB-first bit order
   always_comb begin
      crc_nxt = crc;
      for (int i = 0; i < LANES; i++)
         if (fire && keep[i])
            for (int b = 0; b < 8; b++)
               crc_nxt = (crc_nxt[0] ^ bus.din[8*i+b]) ? ((crc_nxt >> 1) ^ 16'h8408) : (crc_nxt >> 1);
      if (state == IDLE && bus.pkt_start) crc_nxt = 16'hFFFF;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         crc       <= 16'hFFFF;
         crc_err_q <= 1'b0;
      end else begin
         crc       <= crc_nxt;
         crc_err_q <= ftr_done && (crc_nxt != ftr_nxt);
      end
   end

   assign bus.crc_err = crc_err_q;
`else
   assign bus.crc_err = 1'b0;
`endif

   assign bus.pay_valid = pay_valid_q;
   assign bus.pay_data  = pay_data_q;
   assign bus.pay_keep  = pay_keep_q;
   assign bus.pay_last  = pay_last_q;
   assign bus.ftr       = ftr_q;
   assign bus.ftr_valid = ftr_valid_q;
   assign bus.busy      = busy_q;
   assign bus.hdr_err   = hdr_err_q;
endmodule
